// File: rtl/lap_capture.sv
// Lap capture stage between the stopwatch counter and the 4-digit display: stores split
// times in a circular memory, holds a fresh lap on screen, and lets the user recall older laps.
module lap_capture #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 100000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] count,
  input  logic        lapBtn,
  input  logic        recallBtn,
  input  logic        clearBtn,
  output logic [15:0] dispValue,
  output logic        lapMode,
  output logic [2:0]  lapNum,
  output logic [2:0]  lapCount
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned TmrW = $clog2(HOLD_CYCLES);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [TmrW-1:0] HoldLoad = TmrW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StLive, StHold, StRecall} state_e;

  state_e           state_q, state_d;
  logic             lap_prev_q, recall_prev_q, clear_prev_q;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  rd_idx_q, rd_idx_d;
  logic [CntW-1:0]  lap_count_q, lap_count_d;
  logic [TmrW-1:0]  hold_q, hold_d;
  logic [15:0]      disp_q, disp_d;
  logic             mode_q, mode_d;
  logic [2:0]       num_q, num_d;
  logic [15:0]      mem [DEPTH];

  logic             lap_rise, recall_rise, clear_rise;
  logic             do_lap, do_recall;
  logic [PtrW-1:0]  rd_addr;

  assign lap_rise    = lapBtn & ~lap_prev_q;
  assign recall_rise = recallBtn & ~recall_prev_q;
  assign clear_rise  = clearBtn & ~clear_prev_q;

  // Clear beats lap beats recall; losers in the same cycle are dropped.
  assign do_lap    = lap_rise & ~clear_rise;
  assign do_recall = recall_rise & ~clear_rise & ~lap_rise;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_idx_d    = rd_idx_q;
    lap_count_d = lap_count_q;
    hold_d      = hold_q;

    if (clear_rise) begin
      lap_count_d = '0;
      wr_ptr_d    = '0;
      state_d     = StLive;
    end else if (do_lap) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (lap_count_q != DepthCnt) lap_count_d = lap_count_q + 1'b1;
      hold_d  = HoldLoad;
      state_d = StHold;
    end else begin
      unique case (state_q)
        StLive: begin
          if (do_recall && lap_count_q != '0) begin
            state_d  = StRecall;
            rd_idx_d = CntW'(1);
          end
        end
        StHold: begin
          if (do_recall) begin
            state_d  = StRecall;
            rd_idx_d = CntW'(1);
          end else if (hold_q == '0) begin
            state_d = StLive;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        StRecall: begin
          if (do_recall) begin
            if (rd_idx_q < lap_count_q) rd_idx_d = rd_idx_q + 1'b1;
            else state_d = StLive;
          end
        end
        default: state_d = StLive;
      endcase
    end
  end

  // Outputs are derived from the next state so every output changes on the same edge.
  assign rd_addr = wr_ptr_q - PtrW'(rd_idx_d);

  always_comb begin
    disp_d = count;
    mode_d = 1'b0;
    num_d  = 3'd0;
    unique case (state_d)
      StLive: begin
        disp_d = count;
      end
      StHold: begin
        disp_d = do_lap ? count : disp_q;
        mode_d = 1'b1;
        num_d  = 3'd1;
      end
      StRecall: begin
        disp_d = mem[rd_addr];
        mode_d = 1'b1;
        num_d  = 3'(rd_idx_d);
      end
      default: disp_d = count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= StLive;
      lap_prev_q    <= 1'b1;
      recall_prev_q <= 1'b1;
      clear_prev_q  <= 1'b1;
      wr_ptr_q      <= '0;
      rd_idx_q      <= '0;
      lap_count_q   <= '0;
      hold_q        <= '0;
      disp_q        <= '0;
      mode_q        <= 1'b0;
      num_q         <= 3'd0;
    end else begin
      state_q       <= state_d;
      lap_prev_q    <= lapBtn;
      recall_prev_q <= recallBtn;
      clear_prev_q  <= clearBtn;
      wr_ptr_q      <= wr_ptr_d;
      rd_idx_q      <= rd_idx_d;
      lap_count_q   <= lap_count_d;
      hold_q        <= hold_d;
      disp_q        <= disp_d;
      mode_q        <= mode_d;
      num_q         <= num_d;
    end
  end

  // Lap memory is not reset; it is unreachable while no laps are counted.
  always_ff @(posedge CLK) begin
    if (!RST && do_lap) mem[wr_ptr_q] <= count;
  end

  assign dispValue = disp_q;
  assign lapMode   = mode_q;
  assign lapNum    = num_q;
  assign lapCount  = 3'(lap_count_q);

endmodule
